// File: rtl/qspi_mem_responder.sv
// Quad-SPI target answering tinyQV's controller (cmd, addr, mode, dummy, data),
// backed by a byte-wide memory port. All QSPI pins are sampled in the clk domain.
module qspi_mem_responder #(
   parameter int unsigned ADDR_BITS     = 24,
   parameter int unsigned DUMMY_NIBBLES = 4,
   parameter logic [7:0]  CMD_READ      = 8'hEB,
   parameter logic [7:0]  CMD_WRITE     = 8'h38
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 qspi_clk,
   input  logic                 qspi_cs_n,
   input  logic [3:0]           qspi_data_in,
   output logic [3:0]           qspi_data_out,
   output logic [3:0]           qspi_data_oe,
   output logic [ADDR_BITS-1:0] mem_addr,
   output logic                 mem_rd,
   input  logic [7:0]           mem_rdata,
   input  logic                 mem_rd_valid,
   output logic                 mem_wr,
   output logic [7:0]           mem_wdata,
   output logic                 proto_err
);

   // Memory handshake: mem_rd / mem_wr are single-cycle strobes qualified by
   // mem_addr (and mem_wdata); mem_rd_valid is a single-cycle return pulse.
   typedef enum logic [2:0] {
      IDLE, CMD, ADDR, MODE, DUMMY, RDATA, WDATA, IGNORE
   } state_t;

   state_t                 state_q, state_d;
   logic                   sck_q, sck_prev_q;
   logic [7:0]             cnt_q, cnt_d;
   logic                   is_write_q, is_write_d;
   logic [3:0]             cmd_hi_q, cmd_hi_d;
   logic [3:0]             wr_hi_q, wr_hi_d;
   logic [7:0]             rbuf_q, rbuf_d;
   logic                   rvalid_q, rvalid_d;
   logic [3:0]             data_out_q, data_out_d;
   logic [3:0]             oe_q, oe_d;
   logic [ADDR_BITS-1:0]   mem_addr_q, mem_addr_d;
   logic                   mem_rd_q, mem_rd_d;
   logic                   mem_wr_q, mem_wr_d;
   logic [7:0]             mem_wdata_q, mem_wdata_d;
   logic                   err_q, err_d;
   logic                   sck_rise, sck_fall;
   logic [7:0]             cmd_full;

   assign sck_rise = sck_q & ~sck_prev_q;
   assign sck_fall = ~sck_q & sck_prev_q;
   assign cmd_full = {cmd_hi_q, qspi_data_in};

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      is_write_d  = is_write_q;
      cmd_hi_d    = cmd_hi_q;
      wr_hi_d     = wr_hi_q;
      rbuf_d      = rbuf_q;
      rvalid_d    = rvalid_q;
      data_out_d  = data_out_q;
      oe_d        = oe_q;
      mem_addr_d  = mem_addr_q;
      mem_rd_d    = 1'b0;
      mem_wr_d    = 1'b0;
      mem_wdata_d = mem_wdata_q;
      err_d       = err_q;

      // Write address advances the cycle after its strobe.
      if (mem_wr_q) begin
         mem_addr_d = mem_addr_q + ADDR_BITS'(1);
      end

      case (state_q)
         IDLE: begin
            if (!qspi_cs_n) begin
               state_d = CMD;
               cnt_d   = 8'd0;
               err_d   = 1'b0;
            end
         end
         CMD: begin
            if (sck_rise) begin
               cmd_hi_d = qspi_data_in;
               cnt_d    = cnt_q + 8'd1;
               if (cnt_q[0]) begin
                  cnt_d = 8'd0;
                  if (cmd_full == CMD_READ) begin
                     is_write_d = 1'b0;
                     state_d    = ADDR;
                  end else if (cmd_full == CMD_WRITE) begin
                     is_write_d = 1'b1;
                     state_d    = ADDR;
                  end else begin
                     state_d = IGNORE;
                     err_d   = 1'b1;
                  end
               end
            end
         end
         ADDR: begin
            if (sck_rise) begin
               mem_addr_d = {mem_addr_q[ADDR_BITS-5:0], qspi_data_in};
               cnt_d      = cnt_q + 8'd1;
               if (cnt_q == 8'd5) begin
                  cnt_d = 8'd0;
                  if (is_write_q) begin
                     state_d = WDATA;
                  end else begin
                     state_d  = MODE;
                     mem_rd_d = 1'b1;
                  end
               end
            end
         end
         MODE: begin
            if (sck_rise) begin
               cnt_d = cnt_q + 8'd1;
               if (cnt_q[0]) begin
                  cnt_d   = 8'd0;
                  state_d = DUMMY;
               end
            end
         end
         DUMMY: begin
            if (sck_rise) begin
               cnt_d = cnt_q + 8'd1;
               if (cnt_q == 8'(DUMMY_NIBBLES - 1)) begin
                  cnt_d   = 8'd0;
                  state_d = RDATA;
               end
            end
         end
         RDATA: begin
            // cnt_q[0] selects high (0) or low (1) nibble of the held byte.
            if (sck_fall) begin
               oe_d = 4'hF;
               if (!rvalid_q) begin
                  err_d = 1'b1;
               end
               if (!cnt_q[0]) begin
                  data_out_d = rvalid_q ? rbuf_q[7:4] : 4'h0;
                  cnt_d      = 8'd1;
               end else begin
                  data_out_d = rvalid_q ? rbuf_q[3:0] : 4'h0;
                  rvalid_d   = 1'b0;
                  mem_addr_d = mem_addr_q + ADDR_BITS'(1);
                  mem_rd_d   = 1'b1;
                  cnt_d      = 8'd0;
               end
            end
         end
         WDATA: begin
            if (sck_rise) begin
               if (!cnt_q[0]) begin
                  wr_hi_d = qspi_data_in;
                  cnt_d   = 8'd1;
               end else begin
                  mem_wdata_d = {wr_hi_q, qspi_data_in};
                  mem_wr_d    = 1'b1;
                  cnt_d       = 8'd0;
               end
            end
         end
         IGNORE: begin
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (mem_rd_valid && (state_q == MODE || state_q == DUMMY || state_q == RDATA)) begin
         rbuf_d   = mem_rdata;
         rvalid_d = 1'b1;
      end

      // Deselect overrides everything in the same cycle, including an SCK edge.
      if (qspi_cs_n) begin
         state_d    = IDLE;
         cnt_d      = 8'd0;
         oe_d       = 4'h0;
         data_out_d = 4'h0;
         rvalid_d   = 1'b0;
         mem_rd_d   = 1'b0;
         mem_wr_d   = 1'b0;
         err_d      = err_q;
         mem_addr_d = mem_wr_q ? mem_addr_q + ADDR_BITS'(1) : mem_addr_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         sck_q       <= 1'b0;
         sck_prev_q  <= 1'b0;
         cnt_q       <= 8'd0;
         is_write_q  <= 1'b0;
         cmd_hi_q    <= 4'h0;
         wr_hi_q     <= 4'h0;
         rbuf_q      <= 8'h00;
         rvalid_q    <= 1'b0;
         data_out_q  <= 4'h0;
         oe_q        <= 4'h0;
         mem_addr_q  <= '0;
         mem_rd_q    <= 1'b0;
         mem_wr_q    <= 1'b0;
         mem_wdata_q <= 8'h00;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         sck_q       <= qspi_clk;
         sck_prev_q  <= sck_q;
         cnt_q       <= cnt_d;
         is_write_q  <= is_write_d;
         cmd_hi_q    <= cmd_hi_d;
         wr_hi_q     <= wr_hi_d;
         rbuf_q      <= rbuf_d;
         rvalid_q    <= rvalid_d;
         data_out_q  <= data_out_d;
         oe_q        <= oe_d;
         mem_addr_q  <= mem_addr_d;
         mem_rd_q    <= mem_rd_d;
         mem_wr_q    <= mem_wr_d;
         mem_wdata_q <= mem_wdata_d;
         err_q       <= err_d;
      end
   end

   assign qspi_data_out = data_out_q;
   assign qspi_data_oe  = oe_q;
   assign mem_addr      = mem_addr_q;
   assign mem_rd        = mem_rd_q;
   assign mem_wr        = mem_wr_q;
   assign mem_wdata     = mem_wdata_q;
   assign proto_err     = err_q;

endmodule

// File: doc/qspi_mem_responder.md
Name: qspi_mem_responder

Overview:
- Synthesizable QSPI target that answers tinyQV's quad-SPI controller on the PMOD pins: command, address, dummy, then data.
- Backs the traffic with a simple byte-wide memory port, standing in for one flash/RAM chip select.
- Used in FPGA/emulation builds and by benches that need a cycle-accurate responder in the `clk` domain instead of a behavioural model.
- QSPI pins are sampled in the `clk` domain. SCK period must be ≥ 4 `clk` cycles.

Parameters:
- ADDR_BITS, 24, address width accepted on the bus (upper received bits are discarded)
- DUMMY_NIBBLES, 4, dummy SCK cycles between mode byte and first read data nibble
- CMD_READ, 8'hEB, quad read command
- CMD_WRITE, 8'h38, quad write command

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- qspi_clk  in  1  SCK from controller
- qspi_cs_n  in  1  chip select, active low
- qspi_data_in  in  4  IO[3:0] from controller
- qspi_data_out  out  4  IO[3:0] to controller
- qspi_data_oe  out  4  per-bit output enable, 1 = drive
- mem_addr  out  ADDR_BITS  byte address
- mem_rd  out  1  one-cycle read strobe
- mem_rdata  in  8  read data
- mem_rd_valid  in  1  read data valid, ≤ 2*DUMMY_NIBBLES clk after mem_rd
- mem_wr  out  1  one-cycle write strobe
- mem_wdata  out  8  write data
- proto_err  out  1  sticky error flag, cleared by a new CS assertion

Behaviour:
- Clock/reset:
  - One clock `clk`. Reset is asynchronous, active-low, on `rst_n`.
  - Reset values: qspi_data_out=0, qspi_data_oe=0, mem_rd=0, mem_wr=0, mem_addr=0, mem_wdata=0, proto_err=0, state=IDLE.
- Edge detection:
  - qspi_clk is registered once in `clk`. Rise/fall = current vs previous registered value.
  - On a rise, qspi_data_in is sampled in the same cycle.
  - On a fall, qspi_data_out is updated one clk later.
- Nibble order: MSB nibble first for command, address and data bytes.
- FSM states: IDLE, CMD, ADDR, MODE, DUMMY, RDATA, WDATA, IGNORE.
  - IDLE → CMD when cs_n falls.
  - CMD: 2 nibbles. Then:
    - CMD_READ → ADDR (read)
    - CMD_WRITE → ADDR (write)
    - anything else → IGNORE, with proto_err=1
  - ADDR: 6 nibbles, left-shifted into the address register.
  - ADDR → read: MODE (2 nibbles, value ignored) → DUMMY (DUMMY_NIBBLES rises) → RDATA.
  - ADDR → write: WDATA.
  - IGNORE holds until cs_n rises.
- Read path:
  - mem_rd pulses 1 clk on the rise completing the last address nibble, with mem_addr = received address.
  - The returned byte is latched on mem_rd_valid.
  - oe = 4'hF from the SCK fall that precedes the first data-sampling rise.
  - Output nibbles are updated on each SCK fall: high nibble, then low nibble.
  - On each low-nibble fall, mem_addr increments by 1 (wraps at 2^ADDR_BITS), and mem_rd pulses to prefetch the next byte.
  - If no valid byte is held when a nibble must be driven: drive 4'h0 and set proto_err.
- Write path:
  - Each completed byte (2 rises) pulses mem_wr for 1 clk, with mem_wdata = byte and mem_addr = current address.
  - The address increments after the pulse.
  - oe stays 0 throughout a write.
- cs_n rising in any state:
  - Next clk: state=IDLE, oe=0, nibble counters cleared.
  - A partial write byte is discarded (no mem_wr).
  - Outstanding read data is dropped.
  - proto_err keeps its value until the next cs_n fall.
- SCK edges while cs_n=1 are ignored.
- A cs_n rise in the same clk as an SCK rise: cs_n wins, and the nibble is not sampled.
- Asynchronous reset mid-transaction: immediately returns to reset values. No strobes are issued.

Test Plan:
- Read, fresh data:
  - Stimulus: mem returns 8'hA5 at addr 24'h000100. Send cmd EB, addr 000100, mode A0, 4 dummy, read 2 bytes.
  - Required: mem_rd with mem_addr=000100, then mem_rd with 000101. Controller receives nibbles A,5,(mem[101] hi),(mem[101] lo). oe=F only during data.
- Write:
  - Stimulus: cmd 38, addr 0000FF, data 12 34, then cs_n high.
  - Required: mem_wr twice, (0000FF,12) then (000100,34). oe never set.
- Unknown command:
  - Stimulus: cmd 03.
  - Required: proto_err=1, no mem strobes, oe=0. The next CS assertion clears proto_err.
- Address wrap:
  - Stimulus: read burst at FFFFFF.
  - Required: second mem_rd has mem_addr=000000.
- Abort mid-write:
  - Stimulus: cs_n rises after 1 data nibble.
  - Required: no mem_wr. A following read command works normally.
- Slow memory:
  - Stimulus: mem_rd_valid held off past the first data fall.
  - Required: drives 4'h0 and proto_err=1.
- Reset mid-transaction:
  - Stimulus: rst_n pulsed low during RDATA.
  - Required: oe=0 asynchronously.
